// File: rtl/rom_table_divider.sv
// Divides a PW-bit dividend by an FW-bit divisor by scanning the divisor's row of a
// shared a*b multiplication ROM, one read per cycle, with valid/ready handshakes.
module rom_table_divider #(
  parameter int FW = 4,
  parameter int PW = 2*FW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [PW-1:0]   dividend,
  input  logic [FW-1:0]   divisor,
  output logic [2*FW-1:0] rom_addr,
  input  logic [PW-1:0]   rom_data,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [FW-1:0]   quotient,
  output logic [PW-1:0]   remainder,
  output logic            exact,
  output logic            err_div0,
  output logic            err_ovf
);

  // state | meaning
  // IDLE  | waiting for operands, start_ready high
  // SCAN  | walking the divisor's ROM row, one entry per cycle
  // DONE  | result presented until done_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [FW-1:0] B_MAX = '1;

  logic [1:0]    state_q,     state_d;
  logic [FW-1:0] b_q,         b_d;
  logic [FW-1:0] best_q,      best_d;
  logic [PW-1:0] prod_q,      prod_d;
  logic [PW-1:0] dividend_q,  dividend_d;
  logic [FW-1:0] divisor_q,   divisor_d;
  logic [FW-1:0] quotient_q,  quotient_d;
  logic [PW-1:0] remainder_q, remainder_d;
  logic          exact_q,     exact_d;
  logic          err_div0_q,  err_div0_d;
  logic          err_ovf_q,   err_ovf_d;

  logic          hit;
  logic [FW-1:0] best_n;
  logic [PW-1:0] prod_n;
  logic [PW-1:0] rem_n;
  logic          ovf_n;

  // Result is formed from the post-update best/prod so the final row entry counts.
  always_comb begin
    hit    = (rom_data <= dividend_q);
    best_n = hit ? b_q : best_q;
    prod_n = hit ? rom_data : prod_q;
    rem_n  = dividend_q - prod_n;
    ovf_n  = (best_n == B_MAX) && (rem_n >= PW'(divisor_q));
  end

  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    best_d      = best_q;
    prod_d      = prod_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    exact_d     = exact_q;
    err_div0_d  = err_div0_q;
    err_ovf_d   = err_ovf_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          dividend_d = dividend;
          divisor_d  = divisor;
          b_d        = '0;
          best_d     = '0;
          prod_d     = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '0;
            remainder_d = dividend;
            err_div0_d  = 1'b1;
            err_ovf_d   = 1'b0;
            exact_d     = 1'b0;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        best_d = best_n;
        prod_d = prod_n;
        // Row is monotonic, so the first entry above the dividend ends the search.
        if (!hit || b_q == B_MAX) begin
          state_d     = DONE;
          quotient_d  = best_n;
          remainder_d = rem_n;
          err_div0_d  = 1'b0;
          err_ovf_d   = ovf_n;
          exact_d     = (rem_n == '0) && !ovf_n;
        end else begin
          b_d = b_q + 1'b1;
        end
      end
      DONE: begin
        if (done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      b_q         <= '0;
      best_q      <= '0;
      prod_q      <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      exact_q     <= 1'b0;
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      b_q         <= b_d;
      best_q      <= best_d;
      prod_q      <= prod_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      exact_q     <= exact_d;
      err_div0_q  <= err_div0_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign start_ready = rst_n && (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign rom_addr    = (state_q == SCAN) ? {divisor_q, b_q} : '0;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign exact       = exact_q;
  assign err_div0    = err_div0_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_rom_table_divider.sv
// Directed and randomized checks of rom_table_divider against an arithmetic
// reference model, with a behavioural multiplication ROM attached.
module tb_rom_table_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic       start_ready;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       done_valid;
  logic       done_ready = 1'b0;
  logic [3:0] quotient;
  logic [7:0] remainder;
  logic       exact;
  logic       err_div0;
  logic       err_ovf;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  rom_table_divider #(.FW(4), .PW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .dividend(dividend), .divisor(divisor),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .done_valid(done_valid), .done_ready(done_ready),
    .quotient(quotient), .remainder(remainder),
    .exact(exact), .err_div0(err_div0), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_addr[7:4] * rom_addr[3:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = cycles done_ready stays low after done_valid.
  task automatic run_op(input int dvd, input int dvs, input int hold, input bit noise);
    int q_true, q_exp, r_exp, lat_exp, k;
    bit ovf_exp, div0_exp, ex_exp;
    div0_exp = (dvs == 0);
    q_true   = div0_exp ? 0 : dvd / dvs;
    ovf_exp  = !div0_exp && (q_true > 15);
    q_exp    = (q_true > 15) ? 15 : q_true;
    r_exp    = dvd - dvs * q_exp;
    ex_exp   = !div0_exp && !ovf_exp && (r_exp == 0);
    lat_exp  = div0_exp ? 1 : (((q_true + 2) < 16) ? q_true + 2 : 16) + 1;

    @(negedge clk);
    check("start_ready_idle", start_ready, 1);
    start_valid = 1'b1;
    dividend    = dvd[7:0];
    divisor     = dvs[3:0];
    @(negedge clk);
    k = 1;
    if (noise) begin
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
    end else begin
      start_valid = 1'b0;
    end
    if (!div0_exp) check("rom_row", rom_addr, {dvs[3:0], 4'd0});
    else           check("rom_addr_div0", rom_addr, 0);
    while (!done_valid && k < 40) begin
      check("start_ready_busy", start_ready, 0);
      @(negedge clk);
      k++;
    end
    start_valid = 1'b0;
    check("latency", k, lat_exp);
    for (int h = 0; h <= hold; h++) begin
      check("done_valid", done_valid, 1);
      check("quotient", quotient, q_exp);
      check("remainder", remainder, r_exp);
      check("exact", exact, ex_exp);
      check("err_div0", err_div0, div0_exp);
      check("err_ovf", err_ovf, ovf_exp);
      check("start_ready_done", start_ready, 0);
      if (h < hold) @(negedge clk);
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check("done_dropped", done_valid, 0);
    check("start_ready_back", start_ready, 1);
    check("quotient_kept", quotient, q_exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_start_ready", start_ready, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_flags", {exact, err_div0, err_ovf}, 0);
    rst_n = 1'b1;

    run_op(56, 8, 0, 0);
    run_op(100, 7, 0, 0);
    run_op(42, 0, 0, 0);
    run_op(200, 3, 0, 1);
    run_op(225, 15, 0, 0);
    run_op(0, 5, 1, 0);
    run_op(255, 1, 0, 0);
    run_op(56, 8, 5, 0);

    for (int i = 0; i < 25; i++)
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));

    // Reset in the middle of a scan must abort without a result.
    @(negedge clk);
    start_valid = 1'b1;
    dividend    = 8'd100;
    divisor     = 4'd7;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_scan_active", rom_addr[7:4], 7);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_done_valid", done_valid, 0);
    check("abort_start_ready", start_ready, 0);
    check("abort_rom_addr", rom_addr, 0);
    check("abort_outputs", {quotient, remainder, exact, err_div0, err_ovf}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", start_ready, 1);
    for (int i = 0; i < 20; i++) begin
      check("abort_no_done", done_valid, 0);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
